// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (5-9 data bits, optional parity, 1/2 stop bits, break detect)
// feeding a show-ahead FIFO whose entries carry per-frame error flags.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 18432000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sourceClk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int TW  = (OVERSAMPLE < 2) ? 1 : $clog2(OVERSAMPLE);
  localparam int AW  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic [TW-1:0] SAMP0 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] SAMP1 = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] VOTE  = TW'(OVERSAMPLE / 2 + 1);

  if (!(OVERSAMPLE == 8 || OVERSAMPLE == 16) || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV < 2) begin : g_bad_params
    $error("uart_rx_fifo: illegal parameter combination");
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  typedef enum logic [2:0] {
    ST_ARM, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK_WAIT
  } state_t;

  state_t               state;
  logic                 rx_s1, rx_s2, rx_d;
  logic [PW-1:0]        presc;
  logic [TW-1:0]        tick_idx;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 perr, ferr, brk, all_zero;

  logic tick, fall, vote_now, vote, stop_last, brk_c, push, rec_ferr;

  assign tick      = (presc == PW'(DIV - 1));
  assign fall      = rx_d & ~rx_s2;
  assign vote_now  = tick && (tick_idx == VOTE);
  assign vote      = maj3(samp[0], samp[1], rx_s2);
  assign stop_last = (bit_cnt == 4'(STOP_BITS - 1));
  // A break is decided on the first stop vote; a second stop bit keeps that verdict.
  assign brk_c     = (bit_cnt == 4'd0) ? (all_zero & ~vote) : brk;
  assign push      = vote_now && (state == ST_STOP) && stop_last;
  assign rec_ferr  = ferr | ~vote | brk_c;

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      state    <= ST_ARM;
      presc    <= '0;
      tick_idx <= '0;
      samp     <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      brk      <= 1'b0;
      all_zero <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        tick_idx <= tick_idx + TW'(1);
        if (tick_idx == SAMP0) samp[0] <= rx_s2;
        if (tick_idx == SAMP1) samp[1] <= rx_s2;
      end
      case (state)
        // Tick index doubles as the "line high" counter while arming.
        ST_ARM: begin
          if (!rx_s2) tick_idx <= '0;
          else if (tick && tick_idx == TW'(OVERSAMPLE - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (fall) begin
            presc    <= '0;
            tick_idx <= '0;
            bit_cnt  <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            brk      <= 1'b0;
            all_zero <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (vote_now) state <= vote ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (vote_now) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (vote) all_zero <= 1'b0;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_now) begin
            perr  <= ((^shreg) ^ vote) != PAR_ODD;
            if (vote) all_zero <= 1'b0;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (vote_now) begin
            if (!vote) ferr <= 1'b1;
            if (bit_cnt == 4'd0) brk <= all_zero & ~vote;
            if (stop_last) begin
              bit_cnt <= '0;
              state   <= brk_c ? ST_BREAK_WAIT : ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_BREAK_WAIT: begin
          if (rx_s2) begin
            tick_idx <= '0;
            state    <= ST_ARM;
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem_data [FIFO_DEPTH];
  logic [2:0]           mem_flag [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rx_ack & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (pop) rx_overrun <= 1'b0;
      else if (push && full) rx_overrun <= 1'b1;
    end
  end

  always_ff @(posedge sourceClk) begin
    if (wr_en) begin
      mem_data[wr_ptr[AW-1:0]] <= shreg;
      mem_flag[wr_ptr[AW-1:0]] <= {perr, rec_ferr, brk_c};
    end
  end

  assign rx_valid      = ~empty;
  assign rx_data       = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign rx_parity_err = ~empty & mem_flag[rd_ptr[AW-1:0]][2];
  assign rx_frame_err  = ~empty & mem_flag[rd_ptr[AW-1:0]][1];
  assign rx_break      = ~empty & mem_flag[rd_ptr[AW-1:0]][0];

endmodule
